// File: rtl/ifu_fetch_pkg.sv
// Shared types and helpers for the IFU fetch controller: FSM state encoding,
// fetch address width and the sequential next-fetch address function.
package ifu_fetch_pkg;

    localparam int FETCH_ADDR_W = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        STALL = 2'b10,
        WFM   = 2'b11
    } fetch_state_t;

    // Halfword address in, halfword address out; 'step' is the fetch size in bytes.
    // Wraps past 2^64 silently because the carry out of the adder is dropped.
    function automatic logic [FETCH_ADDR_W-1:0] fetch_align_next(
        input logic [FETCH_ADDR_W-1:0] addr_hw,
        input logic [FETCH_ADDR_W:0]   step
    );
        logic [FETCH_ADDR_W:0] byte_addr;
        byte_addr = {addr_hw, 1'b0};
        byte_addr = (byte_addr & ~(step - 64'd1)) + step;
        return byte_addr[FETCH_ADDR_W:1];
    endfunction

endpackage

// File: rtl/ifu_fetch_ctl_if.sv
// Fetch-controller boundary bundle: redirects, I-cache status, aligner credits
// in; F1/F2 requests, occupancy and PMU stall event out.
interface ifu_fetch_ctl_if #(
    parameter int CW = 3
);
    import ifu_fetch_pkg::*;

    logic                    exu_flush_final;
    logic [FETCH_ADDR_W-1:0] exu_flush_path_final;
    logic                    dec_tlu_flush_noredir_wb;
    logic                    ifu_bp_kill_next_f2;
    logic [FETCH_ADDR_W-1:0] ifu_bp_btb_target_f2;
    logic                    ic_hit_f2;
    logic                    ifu_ic_mb_empty;
    logic                    ic_dma_active;
    logic                    ic_write_stall;
    logic [CW-1:0]           ifu_fb_consume;

    logic                    ifc_fetch_req_f1;
    logic [FETCH_ADDR_W-1:0] ifc_fetch_addr_f1;
    logic                    ifc_fetch_req_f2;
    logic [FETCH_ADDR_W-1:0] ifc_fetch_addr_f2;
    logic [CW-1:0]           ifc_fb_occ;
    logic                    ifu_pmu_fetch_stall;

    modport master (
        input  exu_flush_final, exu_flush_path_final, dec_tlu_flush_noredir_wb,
               ifu_bp_kill_next_f2, ifu_bp_btb_target_f2, ic_hit_f2,
               ifu_ic_mb_empty, ic_dma_active, ic_write_stall, ifu_fb_consume,
        output ifc_fetch_req_f1, ifc_fetch_addr_f1, ifc_fetch_req_f2,
               ifc_fetch_addr_f2, ifc_fb_occ, ifu_pmu_fetch_stall
    );

    modport slave (
        output exu_flush_final, exu_flush_path_final, dec_tlu_flush_noredir_wb,
               ifu_bp_kill_next_f2, ifu_bp_btb_target_f2, ic_hit_f2,
               ifu_ic_mb_empty, ic_dma_active, ic_write_stall, ifu_fb_consume,
        input  ifc_fetch_req_f1, ifc_fetch_addr_f1, ifc_fetch_req_f2,
               ifc_fetch_addr_f2, ifc_fb_occ, ifu_pmu_fetch_stall
    );

endinterface

// File: rtl/ifu_fb_credit.sv
// Fetch-buffer credit counter: +1 per F1 issue, -consume from the aligner,
// -1 per F2 miss; a flush restarts the count from the same-cycle issue.
module ifu_fb_credit #(
    parameter int FB_DEPTH    = 4,
    parameter int MAX_CONSUME = 2,
    localparam int CW         = $clog2(FB_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          issue,
    input  logic          dec,
    input  logic          clear,
    input  logic [CW-1:0] consume,
    output logic [CW-1:0] occ,
    output logic          full
);

    localparam logic [CW:0]   DEPTH_W   = (CW+1)'(FB_DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FB_DEPTH);
    localparam logic [CW-1:0] MAX_CON_C = CW'(MAX_CONSUME);

    logic [CW:0]   add_w;
    logic [CW:0]   sub_w;
    logic [CW:0]   nxt_w;
    logic [CW-1:0] occ_ns;

    // Over-consumption clamps at zero instead of wrapping.
    always_comb begin
        add_w  = {1'b0, occ} + {{CW{1'b0}}, issue};
        sub_w  = {1'b0, consume} + {{CW{1'b0}}, dec};
        nxt_w  = (add_w > sub_w) ? (add_w - sub_w) : '0;
        if (nxt_w > DEPTH_W) begin
            nxt_w = DEPTH_W;
        end
        occ_ns = clear ? {{(CW-1){1'b0}}, issue} : nxt_w[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            occ <= '0;
        end else begin
            occ <= occ_ns;
        end
    end

    assign full = (occ >= DEPTH_C);

    a_consume_le_occ : assert property (@(posedge clk) disable iff (!rst_l)
        consume <= occ);

    a_consume_le_max : assert property (@(posedge clk) disable iff (!rst_l)
        consume <= MAX_CON_C);

    a_occ_le_depth : assert property (@(posedge clk) disable iff (!rst_l)
        occ <= DEPTH_C);

endmodule

// File: rtl/ifu_fetch_ctl.sv
// IFU fetch-pipe controller: BF->F1->F2 request/address generation, redirect
// arbitration and fetch-buffer credits. Optional IFU_STALL_CNT_EN adds ifu_stall_cnt.
module ifu_fetch_ctl
    import ifu_fetch_pkg::*;
#(
    parameter int          FB_DEPTH    = 4,
    parameter int          MAX_CONSUME = 2,
    parameter int          FETCH_BYTES = 8,
    parameter logic [63:0] RESET_VEC   = 64'h0
) (
    input  logic            clk,
    input  logic            rst_l,
    ifu_fetch_ctl_if.master fif
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [15:0]     ifu_stall_cnt
`endif
);

    localparam int                    CW   = $clog2(FB_DEPTH + 1);
    localparam logic [FETCH_ADDR_W:0] STEP = (FETCH_ADDR_W+1)'(FETCH_BYTES);

    fetch_state_t            state;
    logic                    boot_q;
    logic                    raw_f1;
    logic                    req_f2_q;
    logic                    miss_q;
    logic [FETCH_ADDR_W-1:0] addr_f1;
    logic [FETCH_ADDR_W-1:0] addr_f2;
    logic [FETCH_ADDR_W-1:0] miss_addr;
    logic [FETCH_ADDR_W-1:0] seq_addr;

    logic          flush;
    logic          halt;
    logic          f1_hold;
    logic          consume_any;
    logic          fb_full;
    logic          issue_f1;
    logic          req_f2;
    logic          miss_f2;
    logic          pmu_stall;
    logic [CW-1:0] occ;

    assign flush       = fif.exu_flush_final;
    assign halt        = flush & fif.dec_tlu_flush_noredir_wb;
    assign f1_hold     = fif.ic_dma_active | fif.ic_write_stall;
    assign consume_any = (fif.ifu_fb_consume != '0);

    // F1 issues only if a buffer credit is free now or freed this cycle.
    assign issue_f1 = raw_f1 & ~fif.ifu_bp_kill_next_f2 & ~f1_hold
                    & ~fif.dec_tlu_flush_noredir_wb & (~fb_full | consume_any);

    assign req_f2   = req_f2_q & ~flush;
    assign miss_f2  = req_f2 & ~fif.ic_hit_f2;
    assign seq_addr = fetch_align_next(addr_f1, STEP);

    assign pmu_stall = (state == WFM)
                     | (raw_f1 & ((fb_full & ~consume_any) | f1_hold));

    ifu_fb_credit #(
        .FB_DEPTH    (FB_DEPTH),
        .MAX_CONSUME (MAX_CONSUME)
    ) u_fb_credit (
        .clk     (clk),
        .rst_l   (rst_l),
        .issue   (issue_f1),
        .dec     (miss_f2),
        .clear   (flush),
        .consume (fif.ifu_fb_consume),
        .occ     (occ),
        .full    (fb_full)
    );

    // BF -> F1 and F1 -> F2 stage registers plus the fetch FSM.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            boot_q    <= 1'b0;
            raw_f1    <= 1'b0;
            req_f2_q  <= 1'b0;
            miss_q    <= 1'b0;
            addr_f1   <= '0;
            addr_f2   <= '0;
            miss_addr <= '0;
        end else begin
            boot_q   <= 1'b1;
            miss_q   <= miss_f2;
            req_f2_q <= issue_f1 & ~miss_f2 & ~flush;
            if (issue_f1) begin
                addr_f2 <= addr_f1;
            end
            if (miss_f2) begin
                miss_addr <= addr_f2;
            end

            if (halt) begin
                state  <= IDLE;
                raw_f1 <= 1'b0;
            end else if (flush) begin
                // A pending miss keeps the buffer busy; retarget the refetch instead.
                if (state == WFM) begin
                    miss_addr <= fif.exu_flush_path_final;
                    raw_f1    <= 1'b0;
                end else begin
                    state   <= FETCH;
                    raw_f1  <= 1'b1;
                    addr_f1 <= fif.exu_flush_path_final;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (miss_f2) begin
                            state  <= WFM;
                            raw_f1 <= 1'b0;
                        end else if (fif.ifu_bp_kill_next_f2) begin
                            raw_f1  <= 1'b1;
                            addr_f1 <= fif.ifu_bp_btb_target_f2;
                        end else if (issue_f1) begin
                            addr_f1 <= seq_addr;
                        end
                    end
                    WFM: begin
                        if (fif.ifu_ic_mb_empty && !fif.ic_dma_active && !miss_q) begin
                            state   <= FETCH;
                            raw_f1  <= 1'b1;
                            addr_f1 <= miss_addr;
                        end
                    end
                    default: begin
                        if (!boot_q) begin
                            state   <= FETCH;
                            raw_f1  <= 1'b1;
                            addr_f1 <= RESET_VEC[63:1];
                        end
                    end
                endcase
            end
        end
    end

    assign fif.ifc_fetch_req_f1    = issue_f1;
    assign fif.ifc_fetch_addr_f1   = addr_f1;
    assign fif.ifc_fetch_req_f2    = req_f2;
    assign fif.ifc_fetch_addr_f2   = addr_f2;
    assign fif.ifc_fb_occ          = occ;
    assign fif.ifu_pmu_fetch_stall = pmu_stall;

`ifdef IFU_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ifu_stall_cnt <= '0;
        end else if (halt) begin
            ifu_stall_cnt <= '0;
        end else if (pmu_stall && (ifu_stall_cnt != 16'hFFFF)) begin
            ifu_stall_cnt <= ifu_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_ctl.sv
// Directed bench for ifu_fetch_ctl (FB_DEPTH=4, FETCH_BYTES=8, RESET_VEC=0).
module tb_ifu_fetch_ctl;
    import ifu_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_l;
    int   n_tests;
    int   n_fail;

    ifu_fetch_ctl_if #(.CW(3)) fif ();

`ifdef IFU_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ifu_fetch_ctl #(
        .FB_DEPTH    (4),
        .MAX_CONSUME (2),
        .FETCH_BYTES (8),
        .RESET_VEC   (64'h0)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .fif   (fif.master)
`ifdef IFU_STALL_CNT_EN
        ,
        .ifu_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [62:0] hw(input logic [63:0] byte_addr);
        return byte_addr[63:1];
    endfunction

    function automatic logic [63:0] a1();
        return {fif.ifc_fetch_addr_f1, 1'b0};
    endfunction

    function automatic logic [63:0] a2();
        return {fif.ifc_fetch_addr_f2, 1'b0};
    endfunction

    task automatic idle_in();
        fif.exu_flush_final          = 1'b0;
        fif.exu_flush_path_final     = '0;
        fif.dec_tlu_flush_noredir_wb = 1'b0;
        fif.ifu_bp_kill_next_f2      = 1'b0;
        fif.ifu_bp_btb_target_f2     = '0;
        fif.ic_hit_f2                = 1'b1;
        fif.ifu_ic_mb_empty          = 1'b1;
        fif.ic_dma_active            = 1'b0;
        fif.ic_write_stall           = 1'b0;
        fif.ifu_fb_consume           = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_l   = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #3;
        check("rst_req_f1", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("rst_req_f2", 64'(fif.ifc_fetch_req_f2), 64'd0);
        check("rst_addr_f1", a1(), 64'h0);
        check("rst_addr_f2", a2(), 64'h0);
        check("rst_occ", 64'(fif.ifc_fb_occ), 64'd0);
        check("rst_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd0);
        check("rst_state", 64'(dut.state), 64'(IDLE));

        rst_l = 1'b1;
        settle();
        check("boot_req_f1", 64'(fif.ifc_fetch_req_f1), 64'd0);

        // No consume: exactly four issues fill the buffer
        for (int i = 0; i < 4; i++) begin
            nxt(); settle();
            check("fill_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
            check("fill_addr", a1(), 64'(i * 8));
            check("fill_occ", 64'(fif.ifc_fb_occ), 64'(i));
            if (i > 0) check("fill_addr_f2", a2(), 64'((i - 1) * 8));
        end
        nxt(); settle();
        check("full_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("full_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd1);
        check("full_occ", 64'(fif.ifc_fb_occ), 64'd4);
        check("full_addr", a1(), 64'h20);
        check("full_req_f2", 64'(fif.ifc_fetch_req_f2), 64'd1);
        check("full_addr_f2", a2(), 64'h18);

        nxt(); fif.ifu_fb_consume = 3'd2; settle();
        check("c2_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
        check("c2_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd0);
        check("c2_addr", a1(), 64'h20);
        nxt(); settle();
        check("c2b_occ", 64'(fif.ifc_fb_occ), 64'd3);
        check("c2b_addr", a1(), 64'h28);
        check("c2b_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
        nxt(); settle();
        check("refull_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("refull_occ", 64'(fif.ifc_fb_occ), 64'd4);
        check("refull_addr", a1(), 64'h30);

        // Consume every cycle: back-to-back sequential issues at full
        for (int i = 0; i < 3; i++) begin
            nxt(); fif.ifu_fb_consume = 3'd1; settle();
            check("seq_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
            check("seq_addr", a1(), 64'(64'h30 + i * 8));
            check("seq_occ", 64'(fif.ifc_fb_occ), 64'd4);
        end

        // Miss at F2 0x40 with miss buffer busy for ten cycles
        nxt(); fif.ic_hit_f2 = 1'b0; fif.ifu_ic_mb_empty = 1'b0; settle();
        check("miss_req_f2", 64'(fif.ifc_fetch_req_f2), 64'd1);
        check("miss_addr_f2", a2(), 64'h40);
        check("miss_req_f1", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("miss_addr_f1", a1(), 64'h48);
        for (int i = 0; i < 9; i++) begin
            nxt(); fif.ifu_ic_mb_empty = 1'b0; settle();
            check("wfm_state", 64'(dut.state), 64'(WFM));
            check("wfm_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
            check("wfm_occ", 64'(fif.ifc_fb_occ), 64'd3);
            check("wfm_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd1);
        end
        nxt(); settle();
        check("mbe_state", 64'(dut.state), 64'(WFM));
        check("mbe_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        nxt(); settle();
        check("refetch_state", 64'(dut.state), 64'(FETCH));
        check("refetch_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
        check("refetch_addr", a1(), 64'h40);
        check("refetch_occ", 64'(fif.ifc_fb_occ), 64'd3);
        nxt(); fif.ifu_fb_consume = 3'd1; settle();
        check("post_addr", a1(), 64'h48);
        check("post_occ", 64'(fif.ifc_fb_occ), 64'd4);
        check("post_addr_f2", a2(), 64'h40);

        // Flush, BTB kill and miss in the same cycle: flush wins
        nxt();
        fif.exu_flush_final      = 1'b1;
        fif.exu_flush_path_final = hw(64'h1000);
        fif.ifu_bp_kill_next_f2  = 1'b1;
        fif.ifu_bp_btb_target_f2 = hw(64'h2000);
        fif.ic_hit_f2            = 1'b0;
        fif.ifu_fb_consume       = 3'd1;
        settle();
        check("fk_req_f1", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("fk_req_f2", 64'(fif.ifc_fetch_req_f2), 64'd0);
        nxt(); settle();
        check("fk_state", 64'(dut.state), 64'(FETCH));
        check("fk_addr", a1(), 64'h1000);
        check("fk_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
        check("fk_occ", 64'(fif.ifc_fb_occ), 64'd0);
`ifdef IFU_STALL_CNT_EN
        check("stall_cnt_a", 64'(stall_cnt), 64'd13);
`endif

        // Flush without redirect halts fetch
        nxt(); fif.exu_flush_final = 1'b1; fif.dec_tlu_flush_noredir_wb = 1'b1; settle();
        check("halt_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        nxt(); settle();
        check("halt_state", 64'(dut.state), 64'(IDLE));
        check("halt_req_idle", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("halt_occ", 64'(fif.ifc_fb_occ), 64'd0);
        check("halt_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd0);
        nxt(); fif.exu_flush_final = 1'b1; fif.exu_flush_path_final = hw(64'h80); settle();
        check("wake_req0", 64'(fif.ifc_fetch_req_f1), 64'd0);
        nxt(); settle();
        check("wake_state", 64'(dut.state), 64'(FETCH));
        check("wake_addr", a1(), 64'h80);
        check("wake_req", 64'(fif.ifc_fetch_req_f1), 64'd1);

        // Misaligned flush target realigns on the sequential step
        nxt(); fif.exu_flush_final = 1'b1; fif.exu_flush_path_final = hw(64'h1004); settle();
        check("mis_occ", 64'(fif.ifc_fb_occ), 64'd1);
        nxt(); fif.ifu_fb_consume = 3'd1; settle();
        check("mis_addr", a1(), 64'h1004);
        check("mis_flush_occ", 64'(fif.ifc_fb_occ), 64'd1);
        nxt(); fif.ifu_fb_consume = 3'd1; settle();
        check("align_addr", a1(), 64'h1008);

        // BTB kill alone redirects F1
        nxt();
        fif.ifu_bp_kill_next_f2  = 1'b1;
        fif.ifu_bp_btb_target_f2 = hw(64'h2000);
        fif.ifu_fb_consume       = 3'd1;
        settle();
        check("kill_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("kill_addr", a1(), 64'h1010);
        nxt(); settle();
        check("btb_addr", a1(), 64'h2000);
        check("btb_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
        check("btb_occ", 64'(fif.ifc_fb_occ), 64'd0);

        // Sequential wrap past the top of the address space
        nxt(); fif.exu_flush_final = 1'b1; fif.exu_flush_path_final = hw(64'hFFFF_FFFF_FFFF_FFF8); settle();
        nxt(); fif.ifu_fb_consume = 3'd1; settle();
        check("top_addr", a1(), 64'hFFFF_FFFF_FFFF_FFF8);
        check("top_req", 64'(fif.ifc_fetch_req_f1), 64'd1);

        // DMA hold blocks issue and replays the same address
        nxt(); fif.ic_dma_active = 1'b1; settle();
        check("wrap_addr", a1(), 64'h0);
        check("dma_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("dma_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd1);
        check("dma_occ", 64'(fif.ifc_fb_occ), 64'd1);
        nxt(); settle();
        check("replay_req", 64'(fif.ifc_fetch_req_f1), 64'd1);
        check("replay_addr", a1(), 64'h0);
        check("replay_pmu", 64'(fif.ifu_pmu_fetch_stall), 64'd0);
`ifdef IFU_STALL_CNT_EN
        check("stall_cnt_b", 64'(stall_cnt), 64'd1);
`endif

        // Asynchronous reset in mid-cycle
        rst_l = 1'b0;
        #1;
        check("arst_req", 64'(fif.ifc_fetch_req_f1), 64'd0);
        check("arst_occ", 64'(fif.ifc_fb_occ), 64'd0);
        check("arst_addr", a1(), 64'h0);
        check("arst_state", 64'(dut.state), 64'(IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
